// File: rtl/condexec_unit_if.sv
// Issue-bundle, flag-writeback and squash-counter signals
// shared between the issue stage and the conditional-execution unit.
interface condexec_unit_if #(
    parameter int NLANES = 2,
    parameter int CNT_W  = 16
);
    localparam int AW = $clog2(NLANES + 1);

    logic                  bundlevalid;
    logic [4*NLANES-1:0]   condin;
    logic [NLANES-1:0]     setsin;
    logic [AW-1:0]         acceptn;
    logic                  flagwe;
    logic [3:0]            flagin;
    logic [3:0]            flagmask;
    logic [NLANES-1:0]     validout;
    logic [NLANES-1:0]     execout;
    logic [3:0]            flagsout;
    logic                  squashclr;
    logic [CNT_W-1:0]      squashcnt;

    modport master (
        output bundlevalid, condin, setsin,
        output flagwe, flagin, flagmask, squashclr,
        input  acceptn, validout, execout, flagsout, squashcnt
    );

    modport slave (
        input  bundlevalid, condin, setsin,
        input  flagwe, flagin, flagmask, squashclr,
        output acceptn, validout, execout, flagsout, squashcnt
    );
endinterface

// File: rtl/condexec_unit.sv
// Conditional-execution unit: NZCV flags, condition evaluation,
// flag-hazard prefix acceptance and a saturating squash counter.
module condexec_unit #(
    parameter int NLANES  = 2,
    parameter int MAXPEND = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    condexec_unit_if.slave   bus
);
    localparam int AW = $clog2(NLANES + 1);
    localparam int PW = $clog2(MAXPEND + 1);
    localparam int SW = CNT_W + AW;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic [3:0]        flags;
    logic [PW-1:0]     pend;
    logic [CNT_W-1:0]  cnt;
    logic [NLANES-1:0] vld_q;
    logic [NLANES-1:0] exe_q;

    logic [3:0]        fmask;
    logic [3:0]        fbyp;
    logic [PW-1:0]     run;
    logic              stop;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     nsq;
    logic [NLANES-1:0] accm;
    logic [NLANES-1:0] pass;
    logic [3:0]        code;
    logic [SW-1:0]     sum;
    logic [CNT_W-1:0]  cnt_nx;

    function automatic logic cond_ok(
        input logic [3:0] c,
        input logic [3:0] f
    );
        logic n, z, cy, v;
        n  = f[0];
        z  = f[1];
        cy = f[2];
        v  = f[3];
        unique case (c)
            4'h0: cond_ok = z;
            4'h1: cond_ok = ~z;
            4'h2: cond_ok = cy;
            4'h3: cond_ok = ~cy;
            4'h4: cond_ok = n;
            4'h5: cond_ok = ~n;
            4'h6: cond_ok = v;
            4'h7: cond_ok = ~v;
            4'h8: cond_ok = cy & ~z;
            4'h9: cond_ok = ~cy | z;
            4'hA: cond_ok = (n == v);
            4'hB: cond_ok = (n != v);
            4'hC: cond_ok = ~z & (n == v);
            4'hD: cond_ok = z | (n != v);
            4'hE: cond_ok = 1'b1;
            4'hF: cond_ok = 1'b0;
        endcase
    endfunction

    // Bypassed flags, in-order hazard scan and squash accumulation.
    always_comb begin
        fmask = bus.flagwe ? bus.flagmask : 4'h0;
        fbyp  = (flags & ~fmask) | (bus.flagin & fmask);
        run   = (bus.flagwe && pend != '0) ? pend - PW'(1) : pend;
        stop  = 1'b0;
        acc   = '0;
        nsq   = '0;
        accm  = '0;
        pass  = '0;
        code  = 4'h0;
        for (int i = 0; i < NLANES; i++) begin
            code    = bus.condin[4*i +: 4];
            pass[i] = cond_ok(code, fbyp);
            if (!bus.bundlevalid || reset || stop) begin
                stop = 1'b1;
            end else if (code < 4'hE && run != '0) begin
                stop = 1'b1;
            end else if (pass[i] && bus.setsin[i] &&
                         run == PW'(MAXPEND)) begin
                stop = 1'b1;
            end else begin
                accm[i] = 1'b1;
                acc     = acc + AW'(1);
                if (pass[i] && bus.setsin[i])
                    run = run + PW'(1);
                if (!pass[i])
                    nsq = nsq + AW'(1);
            end
        end
        sum    = SW'(bus.squashclr ? '0 : cnt) + SW'(nsq);
        cnt_nx = (sum > SW'(CMAX)) ? CMAX : sum[CNT_W-1:0];
    end

    assign bus.acceptn   = acc;
    assign bus.validout  = vld_q;
    assign bus.execout   = exe_q;
    assign bus.flagsout  = flags;
    assign bus.squashcnt = cnt;

    // Architectural state and registered per-lane results.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'h0;
            pend  <= '0;
            cnt   <= '0;
            vld_q <= '0;
            exe_q <= '0;
        end else begin
            flags <= fbyp;
            pend  <= run;
            cnt   <= cnt_nx;
            vld_q <= accm;
            exe_q <= accm & pass;
        end
    end
endmodule

// File: tb/tb_condexec_unit.sv
// Scoreboard bench for condexec_unit (NLANES=2, MAXPEND=3,
// CNT_W=2) with directed scenarios, a code sweep and random traffic.
module tb_condexec_unit;
    localparam int MAXP = 3;
    localparam int CMX  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    condexec_unit_if #(.NLANES(2), .CNT_W(2)) bus ();

    condexec_unit #(
        .NLANES(2), .MAXPEND(MAXP), .CNT_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int nvec = 0;
    int nmis = 0;

    logic [3:0] mflags = 4'h0;
    int         mp     = 0;
    int         mcnt   = 0;

    typedef struct packed {
        logic [1:0] v;
        logic [1:0] e;
        logic [3:0] f;
        logic [1:0] c;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit mcond(
        input logic [3:0] c,
        input logic [3:0] f
    );
        bit n, z, cy, v;
        n = f[0]; z = f[1]; cy = f[2]; v = f[3];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(
        input  bit         bv,
        input  logic [7:0] c,
        input  logic [1:0] s,
        input  bit         fwe,
        input  logic [3:0] fin,
        input  logic [3:0] fm,
        input  bit         sclr,
        input  bit         rs,
        output int         acc
    );
        logic [3:0] m, fb, ci;
        logic [1:0] ev, ee;
        int run, ea, sq;
        bit ex, halt;
        exp_t e;
        @(negedge clk);
        reset           = rs;
        bus.bundlevalid = bv;
        bus.condin      = c;
        bus.setsin      = s;
        bus.flagwe      = fwe;
        bus.flagin      = fin;
        bus.flagmask    = fm;
        bus.squashclr   = sclr;
        #1;
        m   = fwe ? fm : 4'h0;
        fb  = (mflags & ~m) | (fin & m);
        run = (fwe && mp > 0) ? mp - 1 : mp;
        ea = 0; sq = 0; ev = 2'b00; ee = 2'b00; halt = 0;
        if (bv && !rs) begin
            for (int i = 0; i < 2; i++) begin
                if (!halt) begin
                    ci = c[4*i +: 4];
                    ex = mcond(ci, fb);
                    if (ci < 4'hE && run > 0) halt = 1;
                    else if (ex && s[i] && run == MAXP) halt = 1;
                    else begin
                        ev[i] = 1'b1;
                        ee[i] = ex;
                        ea++;
                        if (ex && s[i]) run++;
                        if (!ex) sq++;
                    end
                end
            end
        end
        chk("acceptn", 32'(bus.acceptn), 32'(ea));
        acc = int'(bus.acceptn);
        if (rs) begin
            mflags = 4'h0; mp = 0; mcnt = 0; ev = 2'b00; ee = 2'b00;
        end else begin
            mflags = fb;
            mp     = run;
            mcnt   = (sclr ? 0 : mcnt) + sq;
            if (mcnt > CMX) mcnt = CMX;
        end
        e.v = ev; e.e = ee; e.f = mflags; e.c = 2'(mcnt);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("validout",  32'(bus.validout),  32'(e.v));
        chk("execout",   32'(bus.execout),   32'(e.e));
        chk("flagsout",  32'(bus.flagsout),  32'(e.f));
        chk("squashcnt", 32'(bus.squashcnt), 32'(e.c));
    endtask

    int a;

    initial begin
        reset = 1'b1;
        bus.bundlevalid = 1'b0;
        bus.condin = '0;
        bus.setsin = '0;
        bus.flagwe = 1'b0;
        bus.flagin = '0;
        bus.flagmask = '0;
        bus.squashclr = 1'b0;

        step(0, 8'h00, 2'b00, 0, 4'h0, 4'h0, 0, 1, a);
        step(1, 8'hEE, 2'b11, 1, 4'hF, 4'hF, 0, 1, a);
        chk("rst_acc", 32'(a), 0);
        chk("rst_flags", 32'(bus.flagsout), 0);

        step(1, 8'h10, 2'b00, 0, 4'h0, 4'h0, 0, 0, a);
        chk("eqne_acc", 32'(a), 2);
        chk("eqne_valid", 32'(bus.validout), 32'h3);
        chk("eqne_exec", 32'(bus.execout), 32'h2);
        chk("eqne_sq", 32'(bus.squashcnt), 1);

        step(1, 8'hCE, 2'b01, 0, 4'h0, 4'h0, 0, 0, a);
        chk("alset_acc", 32'(a), 1);
        step(1, 8'hEC, 2'b00, 0, 4'h0, 4'h0, 0, 0, a);
        chk("gt_stall", 32'(a), 0);
        step(1, 8'hEC, 2'b00, 1, 4'h0, 4'hF, 0, 0, a);
        chk("gt_byp_acc", 32'(a), 2);
        chk("gt_byp_exec0", 32'(bus.execout[0]), 1);
        step(1, 8'hCC, 2'b00, 0, 4'h0, 4'h0, 0, 0, a);
        chk("p_zero", 32'(a), 2);

        step(1, 8'hEE, 2'b11, 0, 4'h0, 4'h0, 0, 0, a);
        chk("pend_a", 32'(a), 2);
        step(1, 8'hEE, 2'b11, 0, 4'h0, 4'h0, 0, 0, a);
        chk("pend_b", 32'(a), 1);
        step(1, 8'hEE, 2'b01, 0, 4'h0, 4'h0, 0, 0, a);
        chk("pend_full", 32'(a), 0);
        step(1, 8'hEE, 2'b01, 1, 4'h0, 4'h0, 0, 0, a);
        chk("pend_wb", 32'(a), 2);
        step(1, 8'hEE, 2'b01, 0, 4'h0, 4'h0, 0, 0, a);
        chk("pend_stay", 32'(a), 0);

        step(1, 8'hEE, 2'b00, 0, 4'h0, 4'h0, 0, 0, a);
        step(1, 8'hEE, 2'b00, 1, 4'hF, 4'hF, 0, 1, a);
        chk("midrst_acc", 32'(a), 0);
        chk("midrst_valid", 32'(bus.validout), 0);
        chk("midrst_flags", 32'(bus.flagsout), 0);
        step(1, 8'hCC, 2'b00, 0, 4'h0, 4'h0, 0, 0, a);
        chk("midrst_p0", 32'(a), 2);

        step(0, 8'h00, 2'b00, 1, 4'hF, 4'hF, 0, 0, a);
        step(0, 8'h00, 2'b00, 1, 4'h0, 4'h3, 0, 0, a);
        chk("maskwb", 32'(bus.flagsout), 32'hC);

        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 16; k++) begin
                step(1, {4'((k + 5) % 16), 4'(k)}, 2'b00,
                     1, 4'(f), 4'hF, 0, 0, a);
            end
        end

        step(1, 8'hFF, 2'b00, 0, 4'h0, 4'h0, 1, 0, a);
        step(1, 8'hFF, 2'b00, 0, 4'h0, 4'h0, 0, 0, a);
        step(1, 8'hFF, 2'b00, 0, 4'h0, 4'h0, 0, 0, a);
        chk("sq_sat", 32'(bus.squashcnt), 3);
        step(1, 8'hFF, 2'b11, 0, 4'h0, 4'h0, 1, 0, a);
        chk("sq_clr", 32'(bus.squashcnt), 2);
        chk("nv_exec", 32'(bus.execout), 0);

        for (int r = 0; r < 400; r++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 2'($urandom), $urandom_range(0, 2) == 0,
                 4'($urandom), 4'($urandom),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 39) == 0, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end
endmodule
